// File: rtl/decode_stage_if.sv
// Instruction-in / decoded-packet-out bus of the MIPS decode stage.
// Both directions use valid/ready: a beat transfers on the rising edge where valid and ready are both 1.
// A producer holds valid and its payload steady until that edge.
interface decode_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_rs;
    logic [4:0]      out_rt;
    logic [4:0]      out_cad;
    logic [15:0]     out_imm;
    logic [1:0]      out_type;
    logic            out_gp_we;
    logic            out_mem_wren;
    logic            out_mem_rren;
    logic            out_illegal;
    logic [1:0]      out_pc_sel;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs, out_rt, out_cad, out_imm,
               out_type, out_gp_we, out_mem_wren, out_mem_rren, out_illegal, out_pc_sel
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs, out_rt, out_cad, out_imm,
               out_type, out_gp_we, out_mem_wren, out_mem_rren, out_illegal, out_pc_sel
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: instruction queue feeding a registered decoder output.
// Define DECODE_TRAP_EN to stop the stage after an illegal packet is consumed, until flush or reset.
module decode_stage #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    decode_stage_if.slave          bus,
    output logic                   trapped,
    output logic [$clog2(DEPTH):0] count,
    output logic                   state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

`ifdef DECODE_TRAP_EN
    typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;
`else
    typedef enum logic {RUN = 1'b0} state_t;
`endif

    state_t          state, state_next;
    logic [31:0]     mem_instr [DEPTH];
    logic [PC_W-1:0] mem_pc    [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop, trap_enter, running;

    logic [31:0]     head;
    logic [5:0]      opc, fun;
    logic [4:0]      rs, rt, rd;
    logic            is_i, is_j, is_r, ill, link;
    logic [1:0]      dec_type, dec_pc_sel;
    logic [4:0]      dec_cad;
    logic            dec_gp_we, dec_wren, dec_rren;

    assign running      = (state == RUN);
    assign state_dbg    = state;
    assign bus.in_ready = (count < CW'(DEPTH)) & ~trapped & ~flush;
    assign push         = bus.in_valid & bus.in_ready;
    // The trap-entry cycle must not refill the output register, or that packet would vanish unseen.
    assign pop          = running & ~trap_enter & (count != '0) & (~bus.out_valid | bus.out_ready);

    always_comb begin
        state_next = state;
        trap_enter = 1'b0;
`ifdef DECODE_TRAP_EN
        if (flush) begin
            state_next = RUN;
        end else if (state == RUN && bus.out_valid && bus.out_ready && bus.out_illegal) begin
            trap_enter = 1'b1;
            state_next = TRAP;
        end
        trapped = (state == TRAP);
`else
        trapped = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= bus.in_instr;
            mem_pc[wr_ptr]    <= bus.in_pc;
        end
    end

    assign head = mem_instr[rd_ptr];
    assign opc  = head[31:26];
    assign rs   = head[25:21];
    assign rt   = head[20:16];
    assign rd   = head[15:11];
    assign fun  = head[5:0];

    always_comb begin
        is_i = (opc[5:3] == 3'b001) || (opc == 6'b100011) || (opc == 6'b101011)
            || (opc[5:1] == 5'b00010) || (opc == 6'b000001 && rt[4:1] == 4'b0000)
            || (opc[5:1] == 5'b00011 && rt == 5'b00000);
        is_j = (opc[5:1] == 5'b00001);
        is_r = (opc == 6'b000000 && (fun[5:3] == 3'b100 || fun == 6'b000010
                || fun[5:1] == 5'b10101 || fun == 6'b001000 || fun == 6'b001001
                || fun == 6'b001010 || fun == 6'b001100))
            || (opc == 6'b010000 && (rs == 5'b00000 || rs == 5'b00100
                || (rs == 5'b10000 && fun == 6'b011000)));
        ill  = ~(is_i | is_j | is_r);
        link = (opc == 6'b000011) || (opc == 6'b000000 && fun == 6'b001001);

        if (is_i)      dec_type = 2'b00;
        else if (is_j) dec_type = 2'b01;
        else if (is_r) dec_type = 2'b10;
        else           dec_type = 2'b11;

        if (link)      dec_cad = 5'd31;
        else if (is_r) dec_cad = rd;
        else           dec_cad = rt;

        dec_gp_we = ~ill & ((opc[5:3] == 3'b001) || (opc == 6'b100011) || (opc == 6'b000011)
                            || (opc == 6'b000000 && fun != 6'b001000));
        dec_wren  = ~ill & (opc == 6'b101011);
        dec_rren  = ~ill & (opc == 6'b100011);

        if (opc == 6'b000000 && (fun == 6'b001000 || fun == 6'b001001)) dec_pc_sel = 2'b00;
        else if (opc[5:2] == 4'b0001 || opc == 6'b000001)                dec_pc_sel = 2'b01;
        else if (opc[5:1] == 5'b00001)                                   dec_pc_sel = 2'b10;
        else                                                             dec_pc_sel = 2'b11;
    end

    // Flush shares the reset path so it overrides any push, pop or trap entry in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            bus.out_valid    <= 1'b0;
            bus.out_pc       <= '0;
            bus.out_rs       <= '0;
            bus.out_rt       <= '0;
            bus.out_cad      <= '0;
            bus.out_imm      <= '0;
            bus.out_type     <= '0;
            bus.out_gp_we    <= 1'b0;
            bus.out_mem_wren <= 1'b0;
            bus.out_mem_rren <= 1'b0;
            bus.out_illegal  <= 1'b0;
            bus.out_pc_sel   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (pop) begin
                bus.out_valid    <= 1'b1;
                bus.out_pc       <= mem_pc[rd_ptr];
                bus.out_rs       <= rs;
                bus.out_rt       <= rt;
                bus.out_cad      <= dec_cad;
                bus.out_imm      <= head[15:0];
                bus.out_type     <= dec_type;
                bus.out_gp_we    <= dec_gp_we;
                bus.out_mem_wren <= dec_wren;
                bus.out_mem_rren <= dec_rren;
                bus.out_illegal  <= ill;
                bus.out_pc_sel   <= dec_pc_sel;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage; expectations come from a hand-decoded instruction table.
// Follows DECODE_TRAP_EN the same way the design does.
module tb_decode_stage;
  localparam int DEPTH = 4;
  localparam int PC_W = 32;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PKT_W = PC_W + 39;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  typ;
    logic [4:0]  cad;
    logic        gp_we;
    logic        wren;
    logic        rren;
    logic        ill;
    logic [1:0]  pc_sel;
  } ref_t;

  logic clk, reset, flush, trapped, state_dbg;
  logic [CW-1:0] count;
  decode_stage_if #(.PC_W(PC_W)) bus ();

  decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .trapped(trapped), .count(count), .state_dbg(state_dbg)
  );

  logic [PKT_W-1:0] exp_q[$];
  ref_t pool[12];
  ref_t ill_ref;
  int tests_run, tests_failed, hs_cnt, cyc;
  logic [PC_W-1:0] next_pc;
  bit rnd_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PKT_W-1:0] mk_exp(ref_t r, logic [PC_W-1:0] pc);
    return {pc, r.instr[25:21], r.instr[20:16], r.cad, r.instr[15:0],
            r.typ, r.gp_we, r.wren, r.rren, r.ill, r.pc_sel};
  endfunction

  function automatic logic [PKT_W-1:0] dut_pkt();
    return {bus.out_pc, bus.out_rs, bus.out_rt, bus.out_cad, bus.out_imm, bus.out_type,
            bus.out_gp_we, bus.out_mem_wren, bus.out_mem_rren, bus.out_illegal, bus.out_pc_sel};
  endfunction

  // Scoreboard: every completed output handshake is checked against the oldest accepted instruction.
  always @(negedge clk) begin
    logic [PKT_W-1:0] act, e;
    if (!reset && !flush && bus.out_valid && bus.out_ready) begin
      hs_cnt++;
      tests_run++;
      act = dut_pkt();
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: got %h expected no packet", act);
      end else begin
        e = exp_q.pop_front();
        if (e[2]) begin
          act[28:24] = '0;
          e[28:24] = '0;
        end
        if (act !== e) begin
          tests_failed++;
          $display("FAIL sb_packet: got %h expected %h", act, e);
        end
      end
    end
  end

  task automatic drive_instr(input ref_t r);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = r.instr;
    bus.in_pc = next_pc;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(mk_exp(r, next_pc));
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    next_pc = next_pc + 4;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL push_timeout: instr %h not accepted within 60 cycles", r.instr);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d packets left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h8C220004;
    do_reset();
    bus.in_valid = 1'b0;
    @(negedge clk);
    tests_run += 4;
    if (count !== '0) begin tests_failed++; $display("FAIL rst_count: got %0d expected 0", count); end
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1 || trapped !== 1'b0) begin
      tests_failed++; $display("FAIL rst_ready_trap: got %b/%b expected 1/0", bus.in_ready, trapped);
    end
    if (dut_pkt() !== '0 || state_dbg !== 1'b0) begin
      tests_failed++; $display("FAIL rst_fields: got %h/%b expected 0/0", dut_pkt(), state_dbg);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lw();
    bus.out_ready = 1'b0;
    drive_instr(pool[0]);
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL lw_lat1: got %b expected 0", bus.out_valid); end
    @(posedge clk);
    #1;
    @(negedge clk);
    tests_run += 3;
    if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL lw_lat2: got %b expected 1", bus.out_valid); end
    if ({bus.out_type, bus.out_rt, bus.out_cad} !== {2'b00, 5'd2, 5'd2}) begin
      tests_failed++; $display("FAIL lw_fields: got %b/%0d/%0d expected 00/2/2", bus.out_type, bus.out_rt, bus.out_cad);
    end
    if ({bus.out_gp_we, bus.out_mem_rren, bus.out_mem_wren, bus.out_imm} !== {3'b110, 16'h0004}) begin
      tests_failed++;
      $display("FAIL lw_ctrl: got we=%b rren=%b wren=%b imm=%h expected 1 1 0 0004",
               bus.out_gp_we, bus.out_mem_rren, bus.out_mem_wren, bus.out_imm);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();
  endtask

  task automatic test_jal_jr();
    bus.out_ready = 1'b0;
    drive_instr(pool[3]);
    drive_instr(pool[4]);
    @(negedge clk);
    tests_run++;
    if ({bus.out_valid, bus.out_cad, bus.out_pc_sel, bus.out_type} !== {1'b1, 5'd31, 2'b10, 2'b01}) begin
      tests_failed++;
      $display("FAIL jal_fields: got v=%b cad=%0d sel=%b type=%b expected 1 31 10 01",
               bus.out_valid, bus.out_cad, bus.out_pc_sel, bus.out_type);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    tests_run++;
    if ({bus.out_valid, bus.out_gp_we, bus.out_pc_sel, bus.out_type} !== {1'b1, 1'b0, 2'b00, 2'b10}) begin
      tests_failed++;
      $display("FAIL jr_fields: got v=%b we=%b sel=%b type=%b expected 1 0 00 10",
               bus.out_valid, bus.out_gp_we, bus.out_pc_sel, bus.out_type);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_back_to_back();
    int h0, c0, c1;
    bus.out_ready = 1'b1;
    h0 = hs_cnt;
    c0 = cyc;
    for (int i = 0; i < 8; i++) drive_instr(pool[i]);
    c1 = cyc;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    tests_run += 2;
    if (c1 - c0 != 8) begin tests_failed++; $display("FAIL b2b_accept: got %0d cycles expected 8", c1 - c0); end
    if (hs_cnt - h0 != 8) begin tests_failed++; $display("FAIL b2b_output: got %0d packets expected 8", hs_cnt - h0); end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_backpressure();
    logic [PKT_W-1:0] head;
    bus.out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) drive_instr(pool[(i * 5) % 12]);
    head = exp_q[0];
    bus.in_valid = 1'b1;
    bus.in_instr = pool[9].instr;
    bus.in_pc = next_pc;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run += 2;
      if (count !== CW'(DEPTH) || bus.in_ready !== 1'b0) begin
        tests_failed++; $display("FAIL full_state: got count=%0d ready=%b expected %0d 0", count, bus.in_ready, DEPTH);
      end
      if (bus.out_valid !== 1'b1 || dut_pkt() !== head) begin
        tests_failed++; $display("FAIL hold_stable: got %b %h expected 1 %h", bus.out_valid, dut_pkt(), head);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_pop_ready: got %b expected 0", bus.in_ready); end
    @(posedge clk);
    #1;
    drive_instr(pool[9]);
    drain();
    @(negedge clk);
    tests_run++;
    if (count !== '0 || bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bp_empty: got count=%0d v=%b expected 0 0", count, bus.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    drive_instr(ill_ref);
`ifdef DECODE_TRAP_EN
    @(negedge clk);
    tests_run++;
    if ({bus.out_valid, bus.out_illegal, bus.out_type} !== 4'b1111) begin
      tests_failed++; $display("FAIL ill_present: got v=%b ill=%b type=%b expected 1 1 11", bus.out_valid, bus.out_illegal, bus.out_type);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_instr = pool[2].instr;
    bus.in_pc = next_pc;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if ({trapped, state_dbg, bus.out_valid, bus.in_ready} !== 4'b1100) begin
        tests_failed++;
        $display("FAIL trap_state: got trap=%b st=%b v=%b rdy=%b expected 1 1 0 0", trapped, state_dbg, bus.out_valid, bus.in_ready);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({trapped, state_dbg, bus.in_ready} !== 3'b001 || count !== '0) begin
      tests_failed++; $display("FAIL trap_flush: got trap=%b st=%b rdy=%b count=%0d expected 0 0 1 0", trapped, state_dbg, bus.in_ready, count);
    end
`else
    drive_instr(pool[2]);
    @(negedge clk);
    tests_run++;
    if ({bus.out_valid, bus.out_illegal, bus.out_type, trapped} !== 5'b11110) begin
      tests_failed++; $display("FAIL ill_flow: got v=%b ill=%b type=%b trap=%b expected 1 1 11 0", bus.out_valid, bus.out_illegal, bus.out_type, trapped);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    tests_run++;
    if ({bus.out_valid, bus.out_illegal, trapped} !== 3'b100) begin
      tests_failed++; $display("FAIL ill_next: got v=%b ill=%b trap=%b expected 1 0 0", bus.out_valid, bus.out_illegal, trapped);
    end
`endif
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_instr(pool[i + 5]);
    @(negedge clk);
    tests_run++;
    if (count !== CW'(3)) begin tests_failed++; $display("FAIL flush_pre: got count=%0d expected 3", count); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_instr = pool[1].instr;
    flush = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_ready: got %b expected 0", bus.in_ready); end
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (count !== '0 || bus.out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL flush_post: got count=%0d v=%b expected 0 0", count, bus.out_valid);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int h0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_instr(pool[i + 8]);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    h0 = hs_cnt;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (count !== '0 || bus.out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL rst_mid: got count=%0d v=%b expected 0 0", count, bus.out_valid);
      end
      @(posedge clk);
      #1;
    end
    drive_instr(pool[6]);
    drain();
    tests_run++;
    if (hs_cnt - h0 != 1) begin tests_failed++; $display("FAIL rst_mid_out: got %0d packets expected 1", hs_cnt - h0); end
  endtask

  task automatic test_random();
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) drive_instr(pool[$urandom_range(0, 11)]);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
  endtask

  initial begin
    pool[0]  = '{32'h8C220004, 2'b00, 5'd2,  1'b1, 1'b0, 1'b1, 1'b0, 2'b11};
    pool[1]  = '{32'hAC220008, 2'b00, 5'd2,  1'b0, 1'b1, 1'b0, 1'b0, 2'b11};
    pool[2]  = '{32'h20010001, 2'b00, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
    pool[3]  = '{32'h0C000010, 2'b01, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
    pool[4]  = '{32'h03E00008, 2'b10, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    pool[5]  = '{32'h00221820, 2'b10, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
    pool[6]  = '{32'h10220003, 2'b00, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
    pool[7]  = '{32'h08000005, 2'b01, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
    pool[8]  = '{32'h0020F809, 2'b10, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    pool[9]  = '{32'h40026000, 2'b10, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11};
    pool[10] = '{32'h04200002, 2'b00, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
    pool[11] = '{32'h18200004, 2'b00, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
    ill_ref  = '{32'hFC000000, 2'b11, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'b11};
    tests_run = 0;
    tests_failed = 0;
    hs_cnt = 0;
    cyc = 0;
    next_pc = 32'h0000_1000;
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_lw();
    test_jal_jr();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
